// File: rtl/ef_uart_wb_seq_if.sv
// Wishbone classic bus between the UART sequencer (master) and the EF_UART_wb slave port.
interface ef_uart_wb_seq_if;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic        ack_i;

  modport master (
    output adr_o, dat_o, sel_o, cyc_o, stb_o, we_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, cyc_o, stb_o, we_o,
    output dat_i, ack_i
  );
endinterface

// File: rtl/ef_uart_wb_seq.sv
// Wishbone master that initialises one EF_UART_wb and then shuttles bytes between
// valid/ready TX/RX streams and the UART data registers by polling STATUS.
module ef_uart_wb_seq #(
  parameter logic [31:0] PRESCALE      = 32'd2,
  parameter logic [31:0] CTRL_EN       = 32'd7,
  parameter logic [31:0] PRESCALE_ADDR = 32'h0000_0008,
  parameter logic [31:0] CONTROL_ADDR  = 32'h0000_000C,
  parameter logic [31:0] ICR_ADDR      = 32'h0000_001C,
  parameter logic [31:0] TXDATA_ADDR   = 32'h0000_0004,
  parameter logic [31:0] RXDATA_ADDR   = 32'h0000_0000,
  parameter logic [31:0] STATUS_ADDR   = 32'h0000_0014,
  parameter int          TXFULL_BIT    = 0,
  parameter int          RXEMPTY_BIT   = 1,
  parameter int          TIMEOUT       = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start,
  output logic                  ready,
  output logic                  err,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  ef_uart_wb_seq_if.master      wb
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT0, S_INIT1, S_INIT2, S_INIT3,
    S_POLL, S_DECIDE, S_RDRX, S_WRTX, S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [31:0]      status_q, status_d;
  logic [7:0]       tx_byte_q, tx_byte_d;

  // Per-state bus request; the shared block below turns it into a WB cycle.
  logic             bus_req;
  logic             bus_done;
  logic             req_we;
  logic [31:0]      req_adr;
  logic [31:0]      req_dat;
  state_e           next_after;

  logic             st_rx_empty;
  logic             st_tx_full;

  assign st_rx_empty = |(status_q & (32'd1 << RXEMPTY_BIT));
  assign st_tx_full  = |(status_q & (32'd1 << TXFULL_BIT));

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    err_d      = err_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    status_d   = status_q;
    tx_byte_d  = tx_byte_q;
    bus_req    = 1'b0;
    bus_done   = 1'b0;
    req_we     = 1'b0;
    req_adr    = '0;
    req_dat    = '0;
    next_after = S_IDLE;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_INIT0;
          err_d   = 1'b0;
          ready_d = 1'b0;
        end
      end
      S_INIT0: begin
        bus_req = 1'b1; req_we = 1'b1; req_adr = PRESCALE_ADDR; req_dat = PRESCALE;
        next_after = S_INIT1;
      end
      S_INIT1: begin
        bus_req = 1'b1; req_we = 1'b1; req_adr = CONTROL_ADDR; req_dat = '0;
        next_after = S_INIT2;
      end
      S_INIT2: begin
        bus_req = 1'b1; req_we = 1'b1; req_adr = ICR_ADDR; req_dat = 32'hFF;
        next_after = S_INIT3;
      end
      S_INIT3: begin
        bus_req = 1'b1; req_we = 1'b1; req_adr = CONTROL_ADDR; req_dat = CTRL_EN;
        next_after = S_POLL;
      end
      S_POLL: begin
        bus_req = 1'b1; req_adr = STATUS_ADDR;
        next_after = S_DECIDE;
      end
      S_DECIDE: begin
        // RX has priority, but only when the consumer slot is free.
        if (!st_rx_empty && !rx_valid_q) begin
          state_d = S_RDRX;
        end else if (tx_valid && !st_tx_full) begin
          state_d   = S_WRTX;
          tx_byte_d = tx_data;
        end else begin
          state_d = S_POLL;
        end
      end
      S_RDRX: begin
        bus_req = 1'b1; req_adr = RXDATA_ADDR;
        next_after = S_POLL;
      end
      S_WRTX: begin
        bus_req = 1'b1; req_we = 1'b1; req_adr = TXDATA_ADDR; req_dat = {24'h0, tx_byte_q};
        next_after = S_POLL;
      end
      default: state_d = S_IDLE;
    endcase

    // Issuing only from cyc_q=0 guarantees one idle cycle between transactions.
    if (bus_req) begin
      if (!cyc_q) begin
        cyc_d = 1'b1;
        we_d  = req_we;
        adr_d = req_adr;
        dat_d = req_dat;
        cnt_d = '0;
      end else if (wb.ack_i) begin
        cyc_d    = 1'b0;
        state_d  = next_after;
        bus_done = 1'b1;
      end else if (cnt_q == CNT_LAST) begin
        cyc_d   = 1'b0;
        err_d   = 1'b1;
        ready_d = 1'b0;
        state_d = S_ERR;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (bus_done) begin
      unique case (state_q)
        S_INIT3: ready_d = 1'b1;
        S_POLL:  status_d = wb.dat_i;
        S_RDRX: begin
          rx_data_d  = wb.dat_i[7:0];
          rx_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      status_q   <= '0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      status_q   <= status_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = cyc_q;
  assign wb.we_o  = we_q;
  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.sel_o = {4{cyc_q}};

  assign ready    = ready_q;
  assign err      = err_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = (state_q == S_WRTX) && cyc_q && wb.ack_i;

endmodule
